// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM state encoding and opcode constants.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [5:0] OPRN_MUL = 6'h03;
  localparam logic [5:0] OPRN_MIN = 6'h01;
  localparam logic [5:0] OPRN_MAX = 6'h09;

  function automatic logic oprn_legal(input logic [5:0] oprn);
    return (oprn >= OPRN_MIN) && (oprn <= OPRN_MAX);
  endfunction

endpackage

// File: rtl/alu_arb_grant.sv
// Grant selection for two requesters: a lone request wins outright, a tie goes to the
// requester that was not granted most recently (last_grant = index of previous winner).
module alu_arb_grant (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req_valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = req_valid;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared ALU, one command in flight (IDLE -> EXEC -> RESP).
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is fixed priority to requester 0.
//
// Handshakes: a command moves when req_valid[i] & req_ready[i] at a rising edge; req_ready is only
// ever high in IDLE for the granted requester. A result moves when rsp_valid[g] & rsp_ready[g]; the
// requester must hold req_valid until accepted, and rsp_* stay stable until the result is taken.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int MUL_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_op1,
  input  logic [63:0] req_op2,
  input  logic [11:0] req_oprn,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_out,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [5:0]  alu_oprn,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output state_t      dbg_state
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_LATENCY - 1);

  state_t      state, state_nxt;
  logic [1:0]  gnt_q;
  logic [31:0] op1_q, op2_q;
  logic [5:0]  oprn_q;
  logic [3:0]  cnt_q;
  logic [31:0] rsp_out_q;
  logic        rsp_zero_q, rsp_err_q;

  logic [1:0]  grant;
  logic        last_grant;
  logic        accept, exec_done, rsp_done, op_legal;
  logic [31:0] sel_op1, sel_op2;
  logic [5:0]  sel_oprn;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= grant[1];
    end
  end

  assign last_grant = last_q;
`else
  // Pinning the pointer at requester 1 makes every tie resolve to requester 0.
  assign last_grant = 1'b1;
`endif

  alu_arb_grant u_grant (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign accept    = (state == ST_IDLE) && (grant != 2'b00);
  assign req_ready = (rst && (state == ST_IDLE)) ? grant : 2'b00;
  assign sel_op1   = grant[1] ? req_op1[63:32]  : req_op1[31:0];
  assign sel_op2   = grant[1] ? req_op2[63:32]  : req_op2[31:0];
  assign sel_oprn  = grant[1] ? req_oprn[11:6]  : req_oprn[5:0];
  assign op_legal  = oprn_legal(oprn_q);
  assign exec_done = (state == ST_EXEC) && (cnt_q == 4'd0);
  assign rsp_done  = (state == ST_RESP) && ((rsp_ready & gnt_q) != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)    state_nxt = ST_EXEC;
      ST_EXEC: if (exec_done) state_nxt = ST_RESP;
      ST_RESP: if (rsp_done)  state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q      <= 2'b00;
      op1_q      <= '0;
      op2_q      <= '0;
      oprn_q     <= '0;
      cnt_q      <= '0;
      rsp_out_q  <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        gnt_q  <= grant;
        op1_q  <= sel_op1;
        op2_q  <= sel_op2;
        oprn_q <= sel_oprn;
        cnt_q  <= (sel_oprn == OPRN_MUL) ? MUL_CNT : 4'd0;
      end else if ((state == ST_EXEC) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      // Illegal opcodes never reach the ALU, so their result is forced rather than sampled.
      if (exec_done) begin
        rsp_out_q  <= op_legal ? alu_out : 32'd0;
        rsp_zero_q <= op_legal & alu_zero;
        rsp_err_q  <= ~op_legal;
      end
    end
  end

  always_comb begin
    alu_op1  = 32'd0;
    alu_op2  = 32'd0;
    alu_oprn = 6'd0;
    if (state == ST_EXEC) begin
      alu_op1  = op1_q;
      alu_op2  = op2_q;
      alu_oprn = op_legal ? oprn_q : 6'd0;
    end
  end

  assign rsp_valid = (state == ST_RESP) ? gnt_q : 2'b00;
  assign rsp_out   = rsp_out_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state;

endmodule
